// File: rtl/proc_trace_buf.sv
// Trace capture buffer: FIFO of {addr,data} records drained as 9-byte frames
// (0xA5, addr MSB first, data MSB first) on a valid/ready byte stream.
module proc_trace_buf #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_val,
  input  logic [31:0]              trace_addr,
  input  logic [31:0]              trace_data,
  output logic                     ser_val,
  output logic [7:0]               ser_data,
  input  logic                     ser_rdy,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [63:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [63:0]        head;
  logic [31:0]        word;
  logic               hs, pop, full, push, drop;
  logic [OCC_W-1:0]   occ_d;
  logic               ser_val_d;
  logic [7:0]         ser_data_d;

  // The head record is popped only once its last data byte is accepted.
  assign hs    = ser_val && ser_rdy;
  assign pop   = hs && (state_q == DATA) && (idx_q == 2'd3);
  assign full  = (occupancy == OCC_W'(DEPTH));
  assign push  = trace_val && (!full || pop);
  assign drop  = trace_val && full && !pop;
  assign occ_d = occupancy + OCC_W'(push) - OCC_W'(pop);
  assign head  = mem[rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = 2'd0;
        if (occupancy != '0) state_d = HDR;
      end
      HDR: begin
        if (hs) begin
          state_d = ADDR;
          idx_d   = 2'd0;
        end
      end
      ADDR: begin
        if (hs) begin
          if (idx_q == 2'd3) begin
            state_d = DATA;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      DATA: begin
        if (hs) begin
          if (idx_q == 2'd3) begin
            state_d = (occ_d != '0) ? HDR : IDLE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Output logic: next byte computed from the next state; head only changes
  // on a pop, which always leads to HDR or IDLE.
  always_comb begin
    ser_val_d  = (state_d != IDLE);
    ser_data_d = 8'h00;
    word       = (state_d == ADDR) ? head[63:32] : head[31:0];
    case (state_d)
      HDR: ser_data_d = 8'hA5;
      ADDR, DATA: begin
        case (idx_d)
          2'd0:    ser_data_d = word[31:24];
          2'd1:    ser_data_d = word[23:16];
          2'd2:    ser_data_d = word[15:8];
          default: ser_data_d = word[7:0];
        endcase
      end
      default: ser_data_d = 8'h00;
    endcase
  end

  // Registered stream outputs, pointers and status
  always_ff @(posedge clk) begin
    if (!rst) begin
      ser_val   <= 1'b0;
      ser_data  <= 8'h00;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      ovf       <= 1'b0;
      drop_cnt  <= 8'h00;
    end else begin
      ser_val   <= ser_val_d;
      ser_data  <= ser_data_d;
      occupancy <= occ_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Record storage
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= {trace_addr, trace_data};
  end

endmodule

// File: tb/tb_proc_trace_buf.sv
// Randomized and directed bench for proc_trace_buf against a queue-based frame model.
module tb_proc_trace_buf;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trace_val = 1'b0;
  logic [31:0] trace_addr = '0;
  logic [31:0] trace_data = '0;
  logic        ser_val;
  logic [7:0]  ser_data;
  logic        ser_rdy = 1'b0;
  logic [3:0]  occupancy;
  logic        ovf;
  logic [7:0]  drop_cnt;

  proc_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .trace_val(trace_val), .trace_addr(trace_addr),
    .trace_data(trace_data), .ser_val(ser_val), .ser_data(ser_data),
    .ser_rdy(ser_rdy), .occupancy(occupancy), .ovf(ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int first_edge;

  // Model: queue of accepted records, bytes already sent of the head, frame active
  logic [63:0] mq[$];
  int          sent;
  bit          mact;
  bit          movf;
  int          mdrop;

  logic [7:0]  got[$];
  logic [63:0] recs[$];
  logic [7:0]  exp1[9];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input logic [63:0] r, input int k);
    if (k == 0) return 8'hA5;
    return r[71-8*k -: 8];
  endfunction

  task automatic cycle(input bit rstv, input bit tv, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy);
    int  szb;
    bit  hs, pop, full;
    rst = rstv; trace_val = tv; trace_addr = a; trace_data = d; ser_rdy = rdy;
    if (rstv && ser_val && rdy) begin
      if (got.size() == 0) first_edge = cyc + 1;
      got.push_back(ser_data);
    end
    @(posedge clk);
    cyc++;
    if (!rstv) begin
      mq.delete(); sent = 0; mact = 0; movf = 0; mdrop = 0;
    end else begin
      szb  = mq.size();
      hs   = mact && rdy;
      pop  = hs && (sent == 8);
      full = (szb == DEPTH);
      if (hs) sent++;
      if (pop) begin
        void'(mq.pop_front());
        sent = 0;
      end
      if (tv) begin
        if (!full || pop) mq.push_back({a, d});
        else begin
          movf = 1;
          if (mdrop < 255) mdrop++;
        end
      end
      if (mact) begin
        if (pop) mact = (mq.size() > 0);
      end else begin
        mact = (szb > 0);
      end
    end
    #1;
    check("ser_val", 64'(ser_val), 64'(mact));
    check("ser_data", 64'(ser_data), mact ? 64'(frame_byte(mq[0], sent)) : 64'h0);
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("ovf", 64'(ovf), 64'(movf));
    check("drop_cnt", 64'(drop_cnt), 64'(mdrop));
  endtask

  task automatic push_rec(input logic [31:0] a, input logic [31:0] d, input bit rdy);
    recs.push_back({a, d});
    cycle(1, 1, a, d, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1, 0, '0, '0, rdy);
  endtask

  task automatic check_got(input string tag);
    check({tag, "_len"}, 64'(got.size()), 64'(recs.size() * 9));
    for (int i = 0; i < recs.size(); i++)
      for (int k = 0; k < 9; k++)
        if (i * 9 + k < got.size())
          check(tag, 64'(got[i*9+k]), 64'(frame_byte(recs[i], k)));
  endtask

  initial begin
    int e0;
    logic [31:0] ra, rd;
    exp1 = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};

    // Reset state
    cycle(0, 0, '0, '0, 1);
    cycle(0, 0, '0, '0, 1);

    // Single record with ready held high
    got.delete();
    e0 = cyc + 1;
    cycle(1, 1, 32'h0000_0200, 32'h1234_5678, 1);
    idle(12, 1);
    check("single_len", 64'(got.size()), 64'd9);
    for (int k = 0; k < 9; k++)
      if (k < got.size()) check("single_byte", 64'(got[k]), 64'(exp1[k]));
    check("single_first_edge", 64'(first_edge), 64'(e0 + 2));

    // Backpressure pattern 1,0,0,...
    got.delete();
    cycle(1, 1, 32'h0000_0200, 32'h1234_5678, 1);
    for (int i = 0; i < 30; i++) cycle(1, 0, '0, '0, (i % 3) == 0);
    check("bp_len", 64'(got.size()), 64'd9);
    for (int k = 0; k < 9; k++)
      if (k < got.size()) check("bp_byte", 64'(got[k]), 64'(exp1[k]));

    // Overflow: 10 pushes with consumer stalled
    recs.delete();
    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rd = $urandom;
      if (i < 8) push_rec(ra, rd, 0);
      else cycle(1, 1, ra, rd, 0);
    end
    check("ovf_occ", 64'(occupancy), 64'd8);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_flag", 64'(ovf), 64'd1);

    // Push at full coinciding with the pop of the head record
    got.delete();
    idle(8, 1);
    push_rec(32'hCAFE_0001, 32'hBEEF_0002, 1);
    check("pushpop_occ", 64'(occupancy), 64'd8);
    check("pushpop_drop", 64'(drop_cnt), 64'd2);
    idle(9 * 9 + 5, 1);
    check_got("drain");

    // Drop counter saturation, then reset clears it
    cycle(0, 0, '0, '0, 0);
    for (int i = 0; i < DEPTH + 300; i++) cycle(1, 1, $urandom, $urandom, 0);
    check("sat_drop", 64'(drop_cnt), 64'd255);
    check("sat_ovf", 64'(ovf), 64'd1);
    cycle(0, 0, '0, '0, 0);
    check("sat_rst_drop", 64'(drop_cnt), 64'd0);
    check("sat_rst_ovf", 64'(ovf), 64'd0);

    // Reset after the 4th byte of a frame with 3 records queued
    for (int i = 0; i < 3; i++) cycle(1, 1, $urandom, $urandom, 0);
    idle(4, 1);
    cycle(0, 0, '0, '0, 1);
    check("midrst_val", 64'(ser_val), 64'd0);
    check("midrst_occ", 64'(occupancy), 64'd0);
    got.delete();
    recs.delete();
    push_rec(32'h8000_0004, 32'hDEAD_BEEF, 1);
    idle(12, 1);
    check_got("midrst_frame");

    // Randomized traffic with varying load, stalls and rare resets
    for (int ph = 0; ph < 6; ph++) begin
      int pv, pr;
      pv = $urandom_range(5, 60);
      pr = $urandom_range(20, 100);
      for (int i = 0; i < 600; i++)
        cycle(($urandom_range(0, 499) != 0), ($urandom_range(0, 99) < pv),
              $urandom, $urandom, ($urandom_range(0, 99) < pr));
    end
    idle(100, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
